// File: rtl/coeff_dp_ram.sv
// ---------------------------------------------------------------------------
// coeff_dp_ram
//
// Simple dual-port coefficient RAM with one write port and one read port on a
// single clock. The write port has per-lane enables. The read port has a
// registered output and an optional second output register. A clr pulse
// starts a background zero-fill of the whole array, one word per cycle.
//
// Parameters
//   MEM_WIDTH  data word width in bits
//   MEM_SIZE   number of words (need not be a power of two)
//   NUM_LANES  number of write lanes, MEM_WIDTH must divide evenly
//   OUT_REG    0: read latency 1, 1: read latency 2
//   RDW_MODE   same-address read during write: 0 old data, 1 merged new data
//
// Ports
//   clk         clock, everything on the rising edge
//   rst         synchronous active-high reset (does not touch the array)
//   clr         pulse in IDLE starts the zero-fill
//   busy        high while the zero-fill is running
//   we          write request
//   wr_lane_en  lane i enables bits [i*LW +: LW]
//   wr_addr     write address
//   wr_data     write data
//   re          read request
//   rd_addr     read address
//   rd_data     registered read data, held between rd_valid pulses
//   rd_valid    one-cycle pulse when rd_data has been updated
// ---------------------------------------------------------------------------
module coeff_dp_ram #(
   parameter int MEM_WIDTH = 16,
   parameter int MEM_SIZE  = 1024,
   parameter int NUM_LANES = 2,
   parameter int OUT_REG   = 0,
   parameter int RDW_MODE  = 0,
   localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
   localparam int LW = MEM_WIDTH / NUM_LANES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   output logic                 busy,
   input  logic                 we,
   input  logic [NUM_LANES-1:0] wr_lane_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [MEM_WIDTH-1:0] wr_data,
   input  logic                 re,
   input  logic [AW-1:0]        rd_addr,
   output logic [MEM_WIDTH-1:0] rd_data,
   output logic                 rd_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Clear pointer; it stops at MEM_SIZE-1 so it never walks past the end
   // of a non-power-of-two array.
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;

   logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

   logic                 idle;
   logic                 clr_last;
   logic                 clr_wr;
   logic                 wr_in_range;
   logic                 rd_in_range;
   logic                 wr_go;
   logic                 rd_go;
   logic                 wr_same_addr;
   logic [MEM_WIDTH-1:0] fwd_mask;

   logic [MEM_WIDTH-1:0] rd1_q;
   logic                 rd1_valid_q;

   // ------------------------------------------------------------------
   // Request qualification
   // ------------------------------------------------------------------
   assign idle     = (state_q == IDLE);
   assign busy     = (state_q == CLEAR);
   assign clr_last = (clr_cnt_q == AW'(MEM_SIZE - 1));

   // One extra bit so the compare also works when MEM_SIZE == 2**AW.
   assign wr_in_range = ({1'b0, wr_addr} < (AW + 1)'(MEM_SIZE));
   assign rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(MEM_SIZE));

   // The array itself has no reset, so reset must gate its write enables
   // explicitly to take priority over a user write or a clear step.
   assign clr_wr = busy & ~rst;
   assign wr_go  = idle & ~clr & we & wr_in_range & ~rst;
   assign rd_go  = idle & ~clr & re;

   assign wr_same_addr = (wr_addr == rd_addr);

   // Per-lane forwarding mask for write-first reads: a lane takes the new
   // write data only when that lane is actually being written this cycle.
   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_fwd
         assign fwd_mask[gi*LW +: LW] =
            ((RDW_MODE != 0) && wr_go && wr_same_addr && wr_lane_en[gi])
               ? {LW{1'b1}} : {LW{1'b0}};
      end
   endgenerate

   // ------------------------------------------------------------------
   // Clear FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         CLEAR: begin
            if (clr_last) begin
               state_d   = IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            clr_cnt_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Storage array: zero-fill step or lane-masked user write
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[clr_cnt_q] <= '0;
      end else if (wr_go) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_lane_en[l]) begin
               mem[wr_addr][l*LW +: LW] <= wr_data[l*LW +: LW];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // First read stage. The array read happens before this edge's write,
   // so without forwarding the old word is returned (read-first).
   // Out-of-range addresses return zero with normal timing.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd1_q       <= '0;
         rd1_valid_q <= 1'b0;
      end else begin
         rd1_valid_q <= rd_go;
         if (rd_go) begin
            if (rd_in_range) begin
               rd1_q <= (mem[rd_addr] & ~fwd_mask) | (wr_data & fwd_mask);
            end else begin
               rd1_q <= '0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Optional output register. It advances regardless of the FSM so a
   // read already in flight when a clear starts still completes with its
   // pre-clear data.
   // ------------------------------------------------------------------
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [MEM_WIDTH-1:0] rd2_q;
         logic                 rd2_valid_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               rd2_q       <= '0;
               rd2_valid_q <= 1'b0;
            end else begin
               rd2_valid_q <= rd1_valid_q;
               if (rd1_valid_q) begin
                  rd2_q <= rd1_q;
               end
            end
         end

         assign rd_data  = rd2_q;
         assign rd_valid = rd2_valid_q;
      end else begin : g_no_out_reg
         assign rd_data  = rd1_q;
         assign rd_valid = rd1_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_coeff_dp_ram.sv
// ---------------------------------------------------------------------------
// tb_coeff_dp_ram
//
// Two instances share one stimulus stream:
//   dut0: MEM_SIZE 1024, OUT_REG 0, RDW_MODE 0
//   dut1: MEM_SIZE 1000, OUT_REG 1, RDW_MODE 1
// A behavioural model (word arrays plus a due-cycle schedule of read
// results) predicts busy, rd_valid and rd_data for both every cycle.
// Directed vectors and hand sequences add explicit expected constants.
// ---------------------------------------------------------------------------
module tb_coeff_dp_ram;

   localparam int W  = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst, clr, we, re;
   logic [1:0]    lanes;
   logic [AW-1:0] wa, ra;
   logic [W-1:0]  wd;
   logic          busy0, rv0, busy1, rv1;
   logic [W-1:0]  rd0, rd1;

   always #5 clk = ~clk;

   coeff_dp_ram #(
      .MEM_WIDTH(16), .MEM_SIZE(1024), .NUM_LANES(2), .OUT_REG(0), .RDW_MODE(0)
   ) dut0 (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .we(we),
      .wr_lane_en(lanes), .wr_addr(wa), .wr_data(wd), .re(re),
      .rd_addr(ra), .rd_data(rd0), .rd_valid(rv0)
   );

   coeff_dp_ram #(
      .MEM_WIDTH(16), .MEM_SIZE(1000), .NUM_LANES(2), .OUT_REG(1), .RDW_MODE(1)
   ) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .we(we),
      .wr_lane_en(lanes), .wr_addr(wa), .wr_data(wd), .re(re),
      .rd_addr(ra), .rd_data(rd1), .rd_valid(rv1)
   );

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   int         msize [2] = '{1024, 1000};
   int         mextra[2] = '{0, 1};
   int         mrdw  [2] = '{0, 1};
   logic [15:0] mm   [2][1024];
   bit          mk   [2][1024];
   bit          mbusy[2];
   int          mcnt [2];
   bit          sv   [2][4];
   bit          sk   [2][4];
   logic [15:0] sd   [2][4];
   logic [15:0] mlast  [2];
   bit          mlast_k[2];
   int          cyc;

   int checks = 0;
   int errors = 0;

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                         input logic [1:0] ln);
      logic [15:0] r;
      r = o;
      if (ln[0]) r[7:0]  = n[7:0];
      if (ln[1]) r[15:8] = n[15:8];
      return r;
   endfunction

   task automatic check(input string nm, input int k, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d actual %h required %h", nm, k, cyc, act, exp);
      end
   endtask

   // Advance one clock: predict this edge, then compare after it.
   task automatic cycle();
      int ia, iw, slot;
      logic [15:0] val;
      bit kn, hit;
      cyc++;
      ia = int'(ra);
      iw = int'(wa);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mbusy[k] = 1'b0;
            mcnt[k]  = 0;
            for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            mlast[k]   = 16'h0;
            mlast_k[k] = 1'b1;
         end else if (mbusy[k]) begin
            mm[k][mcnt[k]] = 16'h0;
            mk[k][mcnt[k]] = 1'b1;
            mcnt[k]++;
            if (mcnt[k] == msize[k]) mbusy[k] = 1'b0;
         end else if (clr) begin
            mbusy[k] = 1'b1;
            mcnt[k]  = 0;
         end else begin
            if (re) begin
               if (ia < msize[k]) begin
                  hit = (mrdw[k] != 0) && we && (iw == ia);
                  val = hit ? merge(mm[k][ia], wd, lanes) : mm[k][ia];
                  kn  = mk[k][ia] || (hit && lanes == 2'b11);
               end else begin
                  val = 16'h0;
                  kn  = 1'b1;
               end
               slot = (cyc + mextra[k]) % 4;
               sv[k][slot] = 1'b1;
               sd[k][slot] = val;
               sk[k][slot] = kn;
            end
            if (we && iw < msize[k]) begin
               mm[k][iw] = merge(mm[k][iw], wd, lanes);
               mk[k][iw] = mk[k][iw] || (lanes == 2'b11);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         logic ev;
         slot = cyc % 4;
         ev   = sv[k][slot];
         if (ev) begin
            mlast[k]   = sd[k][slot];
            mlast_k[k] = sk[k][slot];
            sv[k][slot] = 1'b0;
         end
         check("model_busy", k, 16'(k == 0 ? busy0 : busy1), 16'(mbusy[k]));
         check("model_rd_valid", k, 16'(k == 0 ? rv0 : rv1), 16'(ev));
         if (mlast_k[k]) check("model_rd_data", k, (k == 0 ? rd0 : rd1), mlast[k]);
      end
   endtask

   task automatic idle_in();
      rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
      lanes = 2'b00; wa = '0; ra = '0; wd = '0;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(990, 1023));
      return AW'($urandom_range(0, 31));
   endfunction

   task automatic rand_in(input bit allow_ctl);
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      lanes = 2'($urandom_range(0, 3));
      wa    = pick_addr();
      ra    = pick_addr();
      wd    = 16'($urandom);
      clr   = allow_ctl && ($urandom_range(0, 599) == 0);
      rst   = allow_ctl && ($urandom_range(0, 399) == 0);
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d);
      idle_in();
      we = 1'b1; lanes = 2'b11; wa = a; wd = d;
      cycle();
      idle_in();
   endtask

   // Read one address; dut0 answers after one edge, dut1 after two.
   task automatic read_check(input string nm, input logic [AW-1:0] a,
                             input logic [15:0] e0, input logic [15:0] e1);
      idle_in();
      re = 1'b1; ra = a;
      cycle();
      idle_in();
      check({nm, "_valid"}, 0, 16'(rv0), 16'h1);
      check({nm, "_data"},  0, rd0, e0);
      cycle();
      check({nm, "_valid"}, 1, 16'(rv1), 16'h1);
      check({nm, "_data"},  1, rd1, e1);
   endtask

   typedef struct {
      logic          we;
      logic [1:0]    ln;
      logic [AW-1:0] wa;
      logic [15:0]   wd;
      logic          re;
      logic [AW-1:0] ra;
      logic [15:0]   e0;
      logic [15:0]   e1;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int cnt0, cnt1, guard;
      logic [15:0] pre5;

      cyc = 0;
      idle_in();
      rst = 1'b1;

      // Reset state
      repeat (3) cycle();
      check("rst_busy", 0, 16'(busy0), 16'h0);
      check("rst_busy", 1, 16'(busy1), 16'h0);
      check("rst_rd_valid", 0, 16'(rv0), 16'h0);
      check("rst_rd_valid", 1, 16'(rv1), 16'h0);
      check("rst_rd_data", 0, rd0, 16'h0);
      check("rst_rd_data", 1, rd1, 16'h0);
      rst = 1'b0;
      cycle();

      // Directed vectors: {we, lanes, waddr, wdata, re, raddr, exp dut0, exp dut1}
      tbl.push_back('{1'b1, 2'b11, 10'd5,    16'hBEEF, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd5,    16'hBEEF, 16'hBEEF});
      tbl.push_back('{1'b1, 2'b01, 10'd5,    16'h1234, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd5,    16'hBE34, 16'hBE34});
      tbl.push_back('{1'b1, 2'b11, 10'd7,    16'h1111, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b1, 2'b11, 10'd7,    16'h2222, 1'b1, 10'd7,    16'h1111, 16'h2222});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd7,    16'h2222, 16'h2222});
      tbl.push_back('{1'b1, 2'b11, 10'd9,    16'h0F0F, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b1, 2'b00, 10'd9,    16'hFFFF, 1'b1, 10'd9,    16'h0F0F, 16'h0F0F});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd9,    16'h0F0F, 16'h0F0F});
      tbl.push_back('{1'b1, 2'b11, 10'd10,   16'hAAAA, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b1, 2'b10, 10'd10,   16'h5555, 1'b1, 10'd10,   16'hAAAA, 16'h55AA});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd10,   16'h55AA, 16'h55AA});
      tbl.push_back('{1'b1, 2'b11, 10'd1010, 16'h7777, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd1010, 16'h7777, 16'h0000});
      tbl.push_back('{1'b1, 2'b11, 10'd999,  16'h3C3C, 1'b0, 10'd0,    16'h0,    16'h0});
      tbl.push_back('{1'b0, 2'b00, 10'd0,    16'h0000, 1'b1, 10'd999,  16'h3C3C, 16'h3C3C});

      for (int i = 0; i < tbl.size(); i++) begin
         idle_in();
         we = tbl[i].we; lanes = tbl[i].ln; wa = tbl[i].wa; wd = tbl[i].wd;
         re = tbl[i].re; ra = tbl[i].ra;
         cycle();
         idle_in();
         if (tbl[i].re) begin
            check($sformatf("vec%0d_valid", i), 0, 16'(rv0), 16'h1);
            check($sformatf("vec%0d_data", i),  0, rd0, tbl[i].e0);
         end
         cycle();
         if (tbl[i].re) begin
            check($sformatf("vec%0d_valid", i), 1, 16'(rv1), 16'h1);
            check($sformatf("vec%0d_data", i),  1, rd1, tbl[i].e1);
         end
      end

      // Fill everything with non-zero data, then clear.
      for (int a = 0; a < 1024; a++) write_word(AW'(a), 16'($urandom_range(1, 65535)));
      pre5 = mm[1][5];
      idle_in();
      re = 1'b1; ra = 10'd5;
      cycle();
      // clr cycle: its own we/re must be ignored
      idle_in();
      clr = 1'b1; we = 1'b1; lanes = 2'b11; wa = 10'd3; wd = 16'h0;
      re = 1'b1; ra = 10'd4;
      cycle();
      check("inflight_valid", 1, 16'(rv1), 16'h1);
      check("inflight_data",  1, rd1, pre5);
      cnt0  = int'(busy0);
      cnt1  = int'(busy1);
      guard = 0;
      while ((busy0 || busy1) && guard < 1100) begin
         if (guard < 990) begin
            rand_in(1'b0);
            clr = 1'($urandom_range(0, 1));
         end else begin
            idle_in();
         end
         cycle();
         cnt0 += int'(busy0);
         cnt1 += int'(busy1);
         guard++;
      end
      idle_in();
      check("busy_cycles", 0, 16'(cnt0), 16'd1024);
      check("busy_cycles", 1, 16'(cnt1), 16'd1000);
      read_check("clr_addr0",    10'd0,    16'h0, 16'h0);
      read_check("clr_addr511",  10'd511,  16'h0, 16'h0);
      read_check("clr_addr1023", 10'd1023, 16'h0, 16'h0);
      read_check("clr_addr999",  10'd999,  16'h0, 16'h0);

      // Reset in the middle of a clear
      for (int a = 0; a < 31; a++) write_word(AW'(a), 16'(16'h0100 + a));
      write_word(10'd20, 16'h2020);
      idle_in();
      clr = 1'b1;
      cycle();
      idle_in();
      repeat (10) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midclr_busy", 0, 16'(busy0), 16'h0);
      check("midclr_busy", 1, 16'(busy1), 16'h0);
      check("midclr_rd_valid", 0, 16'(rv0), 16'h0);
      check("midclr_rd_valid", 1, 16'(rv1), 16'h0);
      check("midclr_rd_data", 0, rd0, 16'h0);
      check("midclr_rd_data", 1, rd1, 16'h0);
      for (int a = 0; a < 10; a++) read_check("midclr_zeroed", AW'(a), 16'h0, 16'h0);
      read_check("midclr_addr10", 10'd10, 16'h010A, 16'h010A);
      read_check("midclr_addr20", 10'd20, 16'h2020, 16'h2020);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rand_in(1'b1);
         cycle();
      end
      idle_in();
      repeat (3) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
